// File: rtl/branch_fetch_redirect_if.sv
// Signal bundle tying the fetch redirect unit to the branch unit, instruction memory and decode.
// The master modport is the fetch unit's view; slave is the surrounding environment.
interface branch_fetch_redirect_if #(
    parameter int unsigned BUNDLE_BYTES = 16
);
    logic                      br_valid;
    logic                      br_taken;
    logic [31:0]               br_target;
    logic                      imem_req_valid;
    logic                      imem_req_ready;
    logic [31:0]               imem_req_addr;
    logic                      imem_rsp_valid;
    logic [8*BUNDLE_BYTES-1:0] imem_rsp_data;
    logic                      dec_valid;
    logic                      dec_ready;
    logic [31:0]               dec_pc;
    logic [8*BUNDLE_BYTES-1:0] dec_bundle;
    logic                      flush_out;
    logic                      misalign;

    modport master (
        input  br_valid, br_taken, br_target, imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_ready,
        output imem_req_valid, imem_req_addr, dec_valid, dec_pc, dec_bundle, flush_out, misalign
    );

    modport slave (
        output br_valid, br_taken, br_target, imem_req_ready, imem_rsp_valid, imem_rsp_data, dec_ready,
        input  imem_req_valid, imem_req_addr, dec_valid, dec_pc, dec_bundle, flush_out, misalign
    );
endinterface

// File: rtl/branch_fetch_redirect.sv
// Fetch PC owner: issues in-order bundle fetches under a shared credit limit, redirects on
// taken branches, drops stale responses while draining, and buffers bundles for decode.
module branch_fetch_redirect #(
    parameter int unsigned BUNDLE_BYTES = 16,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned DEPTH        = 2
) (
    input logic                     clk,
    input logic                     rst,
    branch_fetch_redirect_if.master bus
);
    localparam int          DW          = 8 * BUNDLE_BYTES;
    localparam int          AW          = $clog2(DEPTH);
    localparam int          CW          = $clog2(DEPTH + 1);
    localparam int          SW          = CW + 1;
    localparam logic [31:0] STEP        = 32'(BUNDLE_BYTES);
    localparam logic [31:0] OFFSET_MASK = STEP - 32'd1;

    typedef enum logic {RUN, DRAIN} state_t;

    state_t        state;
    state_t        state_n;
    logic [31:0]   pc_q;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] fifo_count;
    logic [AW-1:0] pcq_wr;
    logic [AW-1:0] pcq_rd;
    logic [AW-1:0] fifo_wr;
    logic [AW-1:0] fifo_rd;
    logic [31:0]   pcq_mem   [DEPTH];
    logic [31:0]   fifo_pc   [DEPTH];
    logic [DW-1:0] fifo_data [DEPTH];
    logic          flush_q;
    logic          misalign_q;

    logic          redirect;
    logic          rsp;
    logic          credit_ok;
    logic          req_valid;
    logic          dec_valid;
    logic          req_fire;
    logic          keep;
    logic          pop;
    logic [SW-1:0] in_use;
    logic [CW-1:0] out_after_rsp;

    // Credits cover both in-flight requests and buffered bundles, stale ones included.
    always_comb begin
        redirect      = bus.br_valid & bus.br_taken;
        rsp           = bus.imem_rsp_valid;
        in_use        = SW'(outstanding) + SW'(fifo_count);
        credit_ok     = in_use < SW'(DEPTH);
        out_after_rsp = outstanding - CW'(rsp);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        if (redirect) begin
            state_n = (out_after_rsp != '0) ? DRAIN : RUN;
        end else if (state == DRAIN && rsp && drop_cnt == CW'(1)) begin
            state_n = RUN;
        end
    end

    always_comb begin
        req_valid          = !rst && !redirect && credit_ok;
        dec_valid          = !rst && (fifo_count != '0);
        req_fire           = req_valid && bus.imem_req_ready;
        keep               = rsp && (state == RUN) && !redirect;
        pop                = dec_valid && bus.dec_ready;
        bus.imem_req_valid = req_valid;
        bus.imem_req_addr  = pc_q;
        bus.dec_valid      = dec_valid;
        bus.dec_pc         = fifo_pc[fifo_rd];
        bus.dec_bundle     = fifo_data[fifo_rd];
        bus.flush_out      = !rst && flush_q;
        bus.misalign       = !rst && misalign_q;
    end

    // A redirect overrides the PC step and empties the decode buffer; the PC queue keeps
    // popping on every response so stale entries fall out in order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
            pcq_wr      <= '0;
            pcq_rd      <= '0;
            fifo_wr     <= '0;
            fifo_rd     <= '0;
            fifo_count  <= '0;
            flush_q     <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            outstanding <= outstanding + CW'(req_fire) - CW'(rsp);
            flush_q     <= redirect;
            misalign_q  <= redirect && ((bus.br_target & OFFSET_MASK) != 32'd0);
            if (req_fire) begin
                pcq_wr <= pcq_wr + AW'(1);
            end
            if (rsp) begin
                pcq_rd <= pcq_rd + AW'(1);
            end
            if (redirect) begin
                pc_q       <= bus.br_target & ~OFFSET_MASK;
                drop_cnt   <= out_after_rsp;
                fifo_wr    <= '0;
                fifo_rd    <= '0;
                fifo_count <= '0;
            end else begin
                if (req_fire) begin
                    pc_q <= pc_q + STEP;
                end
                if (rsp && drop_cnt != '0) begin
                    drop_cnt <= drop_cnt - CW'(1);
                end
                if (keep) begin
                    fifo_wr <= fifo_wr + AW'(1);
                end
                if (pop) begin
                    fifo_rd <= fifo_rd + AW'(1);
                end
                fifo_count <= fifo_count + CW'(keep) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) begin
            pcq_mem[pcq_wr] <= pc_q;
        end
        if (keep) begin
            fifo_pc[fifo_wr]   <= pcq_mem[pcq_rd];
            fifo_data[fifo_wr] <= bus.imem_rsp_data;
        end
    end

    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (rst)
        rsp |-> (outstanding != '0));
    a_pcq_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (req_fire && !rsp) |-> (outstanding < CW'(DEPTH)));
    a_state_tracks_drop: assert property (@(posedge clk) disable iff (rst)
        (state == DRAIN) == (drop_cnt != '0));
endmodule
